case_frame_packer: RTL and testbench

Downstream consumer of the `ex_case` output stream (`o_dv`/`o_data`). It collects the bytes of each burst into a store-and-forward FIFO. A burst ends after `GAP` idle cycles, and the packer then marks that byte as the frame's last. Complete frames are replayed on a valid/ready byte stream with an end-of-frame flag, so downstream logic always sees whole frames.

---
 rtl/case_frame_packer.sv | 115 +++++++++++
 tb/tb_case_frame_packer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_frame_packer.sv
// case_frame_packer: gathers ex_case bursts into a store-and-forward FIFO.
// A burst becomes a frame after GAP idle cycles, and only closed frames are
// replayed downstream on a valid/ready byte stream with an end-of-frame flag.
module case_frame_packer #(
    parameter int DEPTH = 16,
    parameter int GAP   = 4
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic                     i_dv,
    input  logic [7:0]               i_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [7:0]               o_data,
    output logic                     o_last,
    output logic                     o_ovf,
    output logic [$clog2(DEPTH):0]   o_frames
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    IDLE_END = 8'(GAP - 1);

    // Each entry: bit 8 = last-of-frame flag, bits 7:0 = data byte.
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] closed;
    logic [7:0]    idle;
    logic          open;
    logic          ovf;

    logic          push;
    logic          drop;
    logic          close;
    logic          pop;

    // Only closed frames are visible, so an open frame can never be drained.
    assign o_valid  = (closed != '0);
    assign o_data   = mem[rd_ptr][7:0];
    assign o_last   = mem[rd_ptr][8];
    assign o_ovf    = ovf;
    assign o_frames = closed;

    // Per-cycle events, all decided from pre-edge state.
    always_comb begin
        push  = 1'b0;
        drop  = 1'b0;
        close = 1'b0;
        pop   = 1'b0;
        if (i_dv) begin
            push = (count != FULL);
            drop = (count == FULL);
        end
        close = open && !i_dv && (idle == IDLE_END);
        pop   = o_valid && o_ready;
    end

    // Pointers, occupancy, closed-frame count and sticky overflow.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            closed <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A close and a pop of some frame's last byte cancel out.
            case ({close, pop && o_last})
                2'b10:   closed <= closed + CNT_ONE;
                2'b01:   closed <= closed - CNT_ONE;
                default: closed <= closed;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    // Frame-open flag and idle-gap counter; dropped bytes still restart the gap.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            open <= 1'b0;
            idle <= '0;
        end else if (i_dv) begin
            idle <= '0;
            if (push) open <= 1'b1;
        end else if (close) begin
            open <= 1'b0;
            idle <= '0;
        end else if (open) begin
            idle <= idle + 8'd1;
        end
    end

    // Storage: bytes are written unflagged; closing flags the newest byte.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 9'd0;
        end else begin
            if (push)  mem[wr_ptr] <= {1'b0, i_data};
            if (close) mem[wr_ptr - PTR_ONE][8] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_case_frame_packer.sv
// Bench for case_frame_packer: table vectors, directed corner sequences and
// randomized traffic checked against a frame-queue reference model.
module tb_case_frame_packer;

    localparam int DEPTH = 16;
    localparam int GAP   = 4;

    logic       sclk;
    logic       rst;
    logic       i_dv;
    logic [7:0] i_data;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_ovf;
    logic [4:0] o_frames;

    int checks = 0;
    int errors = 0;

    // Reference model: stored bytes as {last, data} in arrival order.
    logic [8:0] mq[$];
    bit         m_open;
    int         m_quiet;
    int         m_frames;
    bit         m_ovf;

    typedef struct {
        logic       dv;
        logic [7:0] data;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        int         ef;
    } vec_t;
    vec_t tbl[12];

    case_frame_packer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .i_dv    (i_dv),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_ovf   (o_ovf),
        .o_frames(o_frames)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_open   = 0;
        m_quiet  = 0;
        m_frames = 0;
        m_ovf    = 0;
    endtask

    // One clock of the model, using the state before the edge.
    task automatic model_step(input logic dv, input logic [7:0] d, input logic rdy);
        logic       pop;
        logic [8:0] e;
        int         n;
        pop = (m_frames != 0) && rdy;
        n   = mq.size();
        if (dv) begin
            m_quiet = 0;
            if (n < DEPTH) begin
                mq.push_back({1'b0, d});
                m_open = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_open) begin
            m_quiet++;
            if (m_quiet == GAP) begin
                n = mq.size();
                e = mq[n-1];
                e[8] = 1'b1;
                mq[n-1] = e;
                m_frames++;
                m_open  = 0;
                m_quiet = 0;
            end
        end
        if (pop) begin
            e = mq.pop_front();
            if (e[8]) m_frames--;
        end
    endtask

    task automatic step(input logic dv, input logic [7:0] d, input logic rdy);
        logic [8:0] e;
        i_dv    = dv;
        i_data  = d;
        o_ready = rdy;
        model_step(dv, d, rdy);
        @(posedge sclk);
        #1;
        chk("model_valid", o_valid, m_frames != 0);
        chk("model_frames", o_frames, m_frames);
        chk("model_ovf", o_ovf, m_ovf);
        if (m_frames != 0) begin
            e = mq[0];
            chk("model_data", o_data, e[7:0]);
            chk("model_last", o_last, e[8]);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic expect_out(input string nm, input logic [7:0] d, input logic l, input int f);
        chk({nm, "_valid"}, o_valid, 1'b1);
        chk({nm, "_data"}, o_data, d);
        chk({nm, "_last"}, o_last, l);
        chk({nm, "_frames"}, o_frames, f);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_last", o_last, 1'b0);
        chk("rst_ovf", o_ovf, 1'b0);
        chk("rst_frames", o_frames, 5'd0);
        model_clear();
        i_dv    = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int pdv;
        int prd;

        rst     = 1'b0;
        i_dv    = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        model_clear();

        // Single frame 00..03 with the reader always ready.
        tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};

        #3;
        rst = 1'b1;
        #1;
        chk("por_valid", o_valid, 1'b0);
        chk("por_data", o_data, 8'h00);
        chk("por_last", o_last, 1'b0);
        chk("por_ovf", o_ovf, 1'b0);
        chk("por_frames", o_frames, 5'd0);
        #196;
        @(posedge sclk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            step(tbl[v].dv, tbl[v].data, tbl[v].rdy);
            chk($sformatf("tbl%0d_valid", v), o_valid, tbl[v].ev);
            chk($sformatf("tbl%0d_frames", v), o_frames, tbl[v].ef);
            if (tbl[v].ev) begin
                chk($sformatf("tbl%0d_data", v), o_data, tbl[v].ed);
                chk($sformatf("tbl%0d_last", v), o_last, tbl[v].el);
            end
        end

        // Gap boundary: GAP-1 idles continue the frame, GAP idles close it.
        do_reset();
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 8'hCC, 1'b0);
        idle(3, 1'b0);
        chk("gap_not_yet", o_frames, 5'd0);
        idle(1, 1'b0);
        expect_out("gap_aa", 8'hAA, 1'b0, 1);
        step(1'b0, 8'h00, 1'b1);
        expect_out("gap_bb", 8'hBB, 1'b0, 1);
        step(1'b0, 8'h00, 1'b1);
        expect_out("gap_cc", 8'hCC, 1'b1, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("gap_empty", o_valid, 1'b0);

        step(1'b1, 8'hAA, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        idle(4, 1'b0);
        expect_out("gap2_aa", 8'hAA, 1'b1, 2);
        step(1'b0, 8'h00, 1'b1);
        expect_out("gap2_bb", 8'hBB, 1'b1, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("gap2_empty", o_frames, 5'd0);

        // Backpressure: two frames held, output stable while stalled.
        do_reset();
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        idle(4, 1'b0);
        expect_out("bp_hold0", 8'h10, 1'b0, 2);
        idle(2, 1'b0);
        expect_out("bp_hold1", 8'h10, 1'b0, 2);
        step(1'b0, 8'h00, 1'b1);
        expect_out("bp_11", 8'h11, 1'b1, 2);
        step(1'b0, 8'h00, 1'b1);
        expect_out("bp_20", 8'h20, 1'b1, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_empty", o_valid, 1'b0);

        // Overflow: 20 bytes into a 16-entry FIFO with no reader.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk($sformatf("ovf_byte%0d", i), o_ovf, i >= 16);
        end
        idle(3, 1'b0);
        chk("ovf_not_closed", o_frames, 5'd0);
        idle(1, 1'b0);
        chk("ovf_closed", o_frames, 5'd1);
        for (int i = 0; i < 16; i++) begin
            expect_out($sformatf("ovf_rd%0d", i), 8'(i), i == 15, 1);
            step(1'b0, 8'h00, 1'b1);
        end
        chk("ovf_drained", o_valid, 1'b0);
        chk("ovf_sticky", o_ovf, 1'b1);

        // Pop of frame A's last byte on the edge frame B closes.
        do_reset();
        step(1'b1, 8'h31, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        idle(3, 1'b0);
        expect_out("sim_a", 8'h31, 1'b1, 1);
        step(1'b0, 8'h00, 1'b1);
        expect_out("sim_b", 8'h41, 1'b1, 1);

        // Push and pop together at count 8: the FIFO then takes exactly 8 more.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'h50, 1'b1);
        expect_out("pp_next", 8'h81, 1'b0, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pp_fill_ovf", o_ovf, 1'b0);
        step(1'b1, 8'h68, 1'b0);
        chk("pp_drop_ovf", o_ovf, 1'b1);

        // Reset with one closed and one open frame, then a fresh frame.
        do_reset();
        step(1'b1, 8'h71, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'h72, 1'b0);
        chk("mid_pre_frames", o_frames, 5'd1);
        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        idle(4, 1'b0);
        expect_out("mid_5a", 8'h5A, 1'b1, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("mid_empty", o_valid, 1'b0);

        // Randomized traffic with shifting input density and reader activity.
        do_reset();
        pdv = 60;
        prd = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 25 == 0) begin
                case ($urandom_range(0, 3))
                    0: pdv = 95;
                    1: pdv = 60;
                    2: pdv = 10;
                    default: pdv = 0;
                endcase
                case ($urandom_range(0, 3))
                    0: prd = 100;
                    1: prd = 60;
                    2: prd = 20;
                    default: prd = 0;
                endcase
            end
            step($urandom_range(0, 99) < pdv, 8'($urandom), $urandom_range(0, 99) < prd);
        end
        i_dv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
